// File: rtl/lsu_axi_rd_eng_if.sv
// Bus bundles for the LSU read engine: LSU-side descriptor/return port and
// memory-side AXI4 read channel.

// LSU descriptor in, read beats out. The LSU is the master.
interface lsu_rd_if;
   logic [7:0]  lsu_axi_arid;
   logic [9:0]  lsu_axi_araddr;
   logic [7:0]  lsu_axi_arlen;
   logic [2:0]  lsu_axi_arsize;
   logic [1:0]  lsu_axi_arburst;
   logic [2:0]  lsu_axi_arstr;
   logic [7:0]  lsu_axi_arnum;
   logic        lsu_axi_arvld;
   logic        axi_lsu_arrdy;
   logic [7:0]  axi_lsu_rid;
   logic [63:0] axi_lsu_rdata;
   logic [1:0]  axi_lsu_rresp;
   logic        axi_lsu_rlast;
   logic        axi_lsu_rvld;
   logic        lsu_axi_rrdy;

   modport master (
      output lsu_axi_arid, lsu_axi_araddr, lsu_axi_arlen, lsu_axi_arsize,
             lsu_axi_arburst, lsu_axi_arstr, lsu_axi_arnum, lsu_axi_arvld,
             lsu_axi_rrdy,
      input  axi_lsu_arrdy, axi_lsu_rid, axi_lsu_rdata, axi_lsu_rresp,
             axi_lsu_rlast, axi_lsu_rvld
   );

   modport slave (
      input  lsu_axi_arid, lsu_axi_araddr, lsu_axi_arlen, lsu_axi_arsize,
             lsu_axi_arburst, lsu_axi_arstr, lsu_axi_arnum, lsu_axi_arvld,
             lsu_axi_rrdy,
      output axi_lsu_arrdy, axi_lsu_rid, axi_lsu_rdata, axi_lsu_rresp,
             axi_lsu_rlast, axi_lsu_rvld
   );
endinterface

// AXI4 AR/R channels toward system memory. The engine is the master.
interface mem_rd_if #(parameter int unsigned ADDR_W = 32);
   logic [7:0]        m_arid;
   logic [ADDR_W-1:0] m_araddr;
   logic [7:0]        m_arlen;
   logic [2:0]        m_arsize;
   logic [1:0]        m_arburst;
   logic              m_arvalid;
   logic              m_arready;
   logic [7:0]        m_rid;
   logic [63:0]       m_rdata;
   logic [1:0]        m_rresp;
   logic              m_rlast;
   logic              m_rvalid;
   logic              m_rready;

   modport master (
      output m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid, m_rready,
      input  m_arready, m_rid, m_rdata, m_rresp, m_rlast, m_rvalid
   );

   modport slave (
      input  m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid, m_rready,
      output m_arready, m_rid, m_rdata, m_rresp, m_rlast, m_rvalid
   );
endinterface

// File: rtl/lsu_axi_rd_eng.sv
// LSU read engine: expands one strided load descriptor into one AXI4 INCR
// burst per row and returns the beats through a one-entry pipe register.
module lsu_axi_rd_eng #(
   parameter int unsigned       ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(32'h8000_0000),
   parameter int unsigned       MAX_OUTS  = 4
) (
   input  logic     clk,
   input  logic     rst,
   lsu_rd_if.slave  lsu,
   mem_rd_if.master mem,
   output logic     rd_err
);

   localparam int unsigned CNT_W = $clog2(MAX_OUTS + 1);
   localparam int unsigned CHK_W = 14;
   localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_OUTS);
   localparam logic [CHK_W-1:0] PAGE_C = CHK_W'(4096);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_e;

   state_e            state_q, state_d;
   logic              arrdy_q, arrdy_d;
   logic [7:0]        id_q, id_d;
   logic [9:0]        addr_q, addr_d;
   logic [7:0]        len_q, len_d;
   logic [2:0]        str_q, str_d;
   logic [7:0]        num_q, num_d;
   logic [7:0]        row_q, row_d;
   logic [7:0]        rrow_q, rrow_d;
   logic [CNT_W-1:0]  outs_q, outs_d;
   logic              arvalid_q, arvalid_d;
   logic [ADDR_W-1:0] araddr_q, araddr_d;
   logic              pvld_q, pvld_d;
   logic [7:0]        prid_q, prid_d;
   logic [63:0]       pdata_q, pdata_d;
   logic [1:0]        presp_q, presp_d;
   logic              plast_q, plast_d;
   logic              err_q, err_d;

   logic ar_hs, rready_c, r_hs, rlast_hs, cross_c;
   logic unused_sig;

   // Byte address of row k: word index plus k row strides, scaled to bytes.
   function automatic logic [ADDR_W-1:0] row_addr(input logic [9:0] word0,
                                                  input logic [7:0] row,
                                                  input logic [2:0] str);
      logic [ADDR_W-1:0] word;
      word = ADDR_W'(word0) + (ADDR_W'(row) << (4'(str) + 4'd3));
      return BASE_ADDR + (word << 3);
   endfunction

   // Handshakes, R acceptance and 4 KB crossing of the presented AR.
   always_comb begin
      ar_hs    = arvalid_q & mem.m_arready;
      rready_c = (state_q != S_IDLE) & (~pvld_q | lsu.lsu_axi_rrdy);
      r_hs     = mem.m_rvalid & rready_c;
      rlast_hs = r_hs & mem.m_rlast;
      cross_c  = (CHK_W'(araddr_q[11:0]) + ((CHK_W'(len_q) + CHK_W'(1)) << 3)) > PAGE_C;
   end

   // Next-state: descriptor FSM, AR issue, outstanding count and R pipe.
   always_comb begin
      state_d   = state_q;
      arrdy_d   = arrdy_q;
      id_d      = id_q;
      addr_d    = addr_q;
      len_d     = len_q;
      str_d     = str_q;
      num_d     = num_q;
      row_d     = row_q;
      rrow_d    = rrow_q;
      arvalid_d = arvalid_q;
      araddr_d  = araddr_q;
      pvld_d    = pvld_q;
      prid_d    = prid_q;
      pdata_d   = pdata_q;
      presp_d   = presp_q;
      plast_d   = plast_q;
      err_d     = err_q;
      outs_d    = outs_q + CNT_W'(ar_hs) - CNT_W'(rlast_hs);

      if (r_hs) begin
         pvld_d  = 1'b1;
         prid_d  = id_q;
         pdata_d = mem.m_rdata;
         presp_d = mem.m_rresp;
         plast_d = mem.m_rlast & (rrow_q == num_q);
      end else if (lsu.lsu_axi_rrdy) begin
         pvld_d = 1'b0;
      end
      if (rlast_hs)                       rrow_d = rrow_q + 8'd1;
      if (r_hs && (mem.m_rresp != 2'b00)) err_d  = 1'b1;

      case (state_q)
         S_IDLE: begin
            if (lsu.lsu_axi_arvld) begin
               id_d    = lsu.lsu_axi_arid;
               addr_d  = lsu.lsu_axi_araddr;
               len_d   = lsu.lsu_axi_arlen;
               str_d   = lsu.lsu_axi_arstr;
               num_d   = lsu.lsu_axi_arnum;
               row_d   = 8'd0;
               rrow_d  = 8'd0;
               err_d   = 1'b0;
               arrdy_d = 1'b0;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (ar_hs && cross_c) err_d = 1'b1;
            if (arvalid_q && !mem.m_arready) begin
               arvalid_d = 1'b1;
            end else if (ar_hs && (row_q == num_q)) begin
               arvalid_d = 1'b0;
               state_d   = S_DRAIN;
            end else begin
               row_d = row_q + 8'(ar_hs);
               if (outs_d < MAX_C) begin
                  arvalid_d = 1'b1;
                  araddr_d  = row_addr(addr_q, row_d, str_q);
               end else begin
                  arvalid_d = 1'b0;
               end
            end
         end
         S_DRAIN: begin
            if ((outs_q == '0) && !pvld_q) begin
               arrdy_d = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         arrdy_q   <= 1'b1;
         id_q      <= '0;
         addr_q    <= '0;
         len_q     <= '0;
         str_q     <= '0;
         num_q     <= '0;
         row_q     <= '0;
         rrow_q    <= '0;
         outs_q    <= '0;
         arvalid_q <= 1'b0;
         araddr_q  <= '0;
         pvld_q    <= 1'b0;
         prid_q    <= '0;
         pdata_q   <= '0;
         presp_q   <= '0;
         plast_q   <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         arrdy_q   <= arrdy_d;
         id_q      <= id_d;
         addr_q    <= addr_d;
         len_q     <= len_d;
         str_q     <= str_d;
         num_q     <= num_d;
         row_q     <= row_d;
         rrow_q    <= rrow_d;
         outs_q    <= outs_d;
         arvalid_q <= arvalid_d;
         araddr_q  <= araddr_d;
         pvld_q    <= pvld_d;
         prid_q    <= prid_d;
         pdata_q   <= pdata_d;
         presp_q   <= presp_d;
         plast_q   <= plast_d;
         err_q     <= err_d;
      end
   end

   // Size and burst type are fixed; memory read data arrives in order.
   assign unused_sig = ^{lsu.lsu_axi_arsize, lsu.lsu_axi_arburst, mem.m_rid};

   assign lsu.axi_lsu_arrdy = arrdy_q;
   assign lsu.axi_lsu_rid   = prid_q;
   assign lsu.axi_lsu_rdata = pdata_q;
   assign lsu.axi_lsu_rresp = presp_q;
   assign lsu.axi_lsu_rlast = plast_q;
   assign lsu.axi_lsu_rvld  = pvld_q;

   assign mem.m_arid    = id_q;
   assign mem.m_araddr  = araddr_q;
   assign mem.m_arlen   = len_q;
   assign mem.m_arsize  = arvalid_q ? 3'd3 : 3'd0;
   assign mem.m_arburst = arvalid_q ? 2'b01 : 2'b00;
   assign mem.m_arvalid = arvalid_q;
   assign mem.m_rready  = rready_c;

   assign rd_err = err_q;

endmodule

// File: tb/tb_lsu_axi_rd_eng.sv
// Directed bench for lsu_axi_rd_eng with a small in-order AXI memory model.
module tb_lsu_axi_rd_eng;

   localparam int unsigned ADDR_W = 32;

   logic clk = 1'b0;
   logic rst;
   logic rd_err;

   always #5 clk = ~clk;

   lsu_rd_if lsu ();
   mem_rd_if #(.ADDR_W(ADDR_W)) mem ();

   lsu_axi_rd_eng #(
      .ADDR_W   (ADDR_W),
      .BASE_ADDR(32'h8000_0000),
      .MAX_OUTS (4)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .lsu   (lsu),
      .mem   (mem),
      .rd_err(rd_err)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Memory model / monitor state
   logic        mem_hold  = 1'b0;
   logic        mem_arrdy = 1'b1;
   int          err_gbeat = -1;
   int          gcount    = 0;
   int          cur_beat  = 0;
   int          mem_outs  = 0;
   logic [31:0] pend_addr[$];
   logic [7:0]  pend_len[$];
   logic [63:0] exp_data[$];
   logic [1:0]  exp_resp[$];
   logic [31:0] ar_addr_log[$];
   logic [7:0]  ar_len_log[$];
   logic [12:0] ar_attr_log[$];
   logic        rx_last_log[$];
   logic [1:0]  rx_resp_log[$];
   logic [7:0]  exp_id = 8'h00;
   logic        prev_stall = 1'b0;
   logic [63:0] stall_data;
   logic        stall_last;
   logic [1:0]  stall_resp;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ar_addr_at(input int i);
      return (i < ar_addr_log.size()) ? ar_addr_log[i] : 32'hDEAD_BEEF;
   endfunction
   function automatic logic [7:0] ar_len_at(input int i);
      return (i < ar_len_log.size()) ? ar_len_log[i] : 8'hEE;
   endfunction
   function automatic logic [12:0] ar_attr_at(input int i);
      return (i < ar_attr_log.size()) ? ar_attr_log[i] : 13'h1FFF;
   endfunction
   function automatic logic [1:0] rx_resp_at(input int i);
      return (i < rx_resp_log.size()) ? rx_resp_log[i] : 2'b11;
   endfunction

   // Memory responder and LSU-side monitor: sample 1 ns before each rising
   // edge, drive memory outputs 1 ns after it.
   initial begin
      mem.m_arready = 1'b1;
      mem.m_rvalid  = 1'b0;
      mem.m_rdata   = '0;
      mem.m_rresp   = 2'b00;
      mem.m_rlast   = 1'b0;
      mem.m_rid     = '0;
      forever begin
         @(negedge clk);
         #4;
         if (rst) begin
            pend_addr.delete();
            pend_len.delete();
            exp_data.delete();
            exp_resp.delete();
            cur_beat   = 0;
            mem_outs   = 0;
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) begin
               chk("stall_vld",  64'(lsu.axi_lsu_rvld),  64'(1));
               chk("stall_data", lsu.axi_lsu_rdata,      stall_data);
               chk("stall_last", 64'(lsu.axi_lsu_rlast), 64'(stall_last));
               chk("stall_resp", 64'(lsu.axi_lsu_rresp), 64'(stall_resp));
            end
            prev_stall = lsu.axi_lsu_rvld & ~lsu.lsu_axi_rrdy;
            if (prev_stall) begin
               stall_data = lsu.axi_lsu_rdata;
               stall_last = lsu.axi_lsu_rlast;
               stall_resp = lsu.axi_lsu_rresp;
               chk("rready_full", 64'(mem.m_rready), 64'(0));
            end
            if (lsu.axi_lsu_rvld && lsu.lsu_axi_rrdy) begin
               chk("rx_expected", 64'(exp_data.size() > 0), 64'(1));
               if (exp_data.size() > 0) begin
                  chk("rx_data", lsu.axi_lsu_rdata, exp_data.pop_front());
                  chk("rx_resp", 64'(lsu.axi_lsu_rresp), 64'(exp_resp.pop_front()));
               end
               chk("rx_rid", 64'(lsu.axi_lsu_rid), 64'(exp_id));
               rx_last_log.push_back(lsu.axi_lsu_rlast);
               rx_resp_log.push_back(lsu.axi_lsu_rresp);
            end
            if (mem.m_arvalid && mem.m_arready) begin
               chk("ar_outs_lim", 64'(mem_outs < 4), 64'(1));
               ar_addr_log.push_back(mem.m_araddr);
               ar_len_log.push_back(mem.m_arlen);
               ar_attr_log.push_back({mem.m_arid, mem.m_arsize, mem.m_arburst});
               pend_addr.push_back(mem.m_araddr);
               pend_len.push_back(mem.m_arlen);
               mem_outs++;
            end
            if (mem.m_rvalid && mem.m_rready) begin
               exp_data.push_back(mem.m_rdata);
               exp_resp.push_back(mem.m_rresp);
               gcount++;
               if (mem.m_rlast) begin
                  void'(pend_addr.pop_front());
                  void'(pend_len.pop_front());
                  cur_beat = 0;
                  mem_outs--;
               end else begin
                  cur_beat++;
               end
            end
         end
         @(posedge clk);
         #1;
         mem.m_arready = mem_arrdy;
         if (!mem_hold && pend_addr.size() > 0) begin
            mem.m_rvalid = 1'b1;
            mem.m_rdata  = {32'(gcount), pend_addr[0] + 32'(cur_beat * 8)};
            mem.m_rresp  = (gcount == err_gbeat) ? 2'b10 : 2'b00;
            mem.m_rlast  = (cur_beat == int'(pend_len[0]));
            mem.m_rid    = exp_id;
         end else begin
            mem.m_rvalid = 1'b0;
            mem.m_rdata  = '0;
            mem.m_rresp  = 2'b00;
            mem.m_rlast  = 1'b0;
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic send(input logic [7:0] id, input logic [9:0] addr, input logic [7:0] len,
                       input logic [2:0] str, input logic [7:0] num);
      int t = 0;
      while (lsu.axi_lsu_arrdy !== 1'b1 && t < 100) begin
         step(1);
         t++;
      end
      exp_id              = id;
      lsu.lsu_axi_arid    = id;
      lsu.lsu_axi_araddr  = addr;
      lsu.lsu_axi_arlen   = len;
      lsu.lsu_axi_arstr   = str;
      lsu.lsu_axi_arnum   = num;
      lsu.lsu_axi_arsize  = 3'd0;
      lsu.lsu_axi_arburst = 2'b10;
      lsu.lsu_axi_arvld   = 1'b1;
      step(1);
      lsu.lsu_axi_arvld   = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input bit toggle);
      int t = 0;
      while (lsu.axi_lsu_arrdy !== 1'b1 && t < 2000) begin
         if (toggle) lsu.lsu_axi_rrdy = ~lsu.lsu_axi_rrdy;
         step(1);
         t++;
      end
      lsu.lsu_axi_rrdy = 1'b1;
      chk({tag, "_done"}, 64'(lsu.axi_lsu_arrdy), 64'(1));
   endtask

   task automatic chk_last(input string tag, input int base, input int n);
      logic [63:0] m = '0;
      for (int i = base; i < rx_last_log.size(); i++)
         if (i - base < 64) m[i - base] = rx_last_log[i];
      chk({tag, "_beats"}, 64'(rx_last_log.size() - base), 64'(n));
      chk({tag, "_rlast"}, m, 64'(1) << (n - 1));
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_arrdy"},   64'(lsu.axi_lsu_arrdy), 64'(1));
      chk({tag, "_arvalid"}, 64'(mem.m_arvalid),     64'(0));
      chk({tag, "_araddr"},  64'(mem.m_araddr),      64'(0));
      chk({tag, "_rvld"},    64'(lsu.axi_lsu_rvld),  64'(0));
      chk({tag, "_rlast"},   64'(lsu.axi_lsu_rlast), 64'(0));
      chk({tag, "_rdata"},   lsu.axi_lsu_rdata,      64'(0));
      chk({tag, "_rid"},     64'(lsu.axi_lsu_rid),   64'(0));
      chk({tag, "_rready"},  64'(mem.m_rready),      64'(0));
      chk({tag, "_rd_err"},  64'(rd_err),            64'(0));
   endtask

   initial begin
      int ab, rb, t;
      rst                 = 1'b1;
      lsu.lsu_axi_arid    = '0;
      lsu.lsu_axi_araddr  = '0;
      lsu.lsu_axi_arlen   = '0;
      lsu.lsu_axi_arsize  = '0;
      lsu.lsu_axi_arburst = '0;
      lsu.lsu_axi_arstr   = '0;
      lsu.lsu_axi_arnum   = '0;
      lsu.lsu_axi_arvld   = 1'b0;
      lsu.lsu_axi_rrdy    = 1'b1;
      step(3);
      chk_reset("rst");
      rst = 1'b0;
      step(2);

      // Single row, 4 beats
      ab = ar_addr_log.size(); rb = rx_last_log.size();
      send(8'h5A, 10'h010, 8'd3, 3'd0, 8'd0);
      wait_idle("t1", 1'b0);
      chk("t1_ar_n",   64'(ar_addr_log.size() - ab), 64'(1));
      chk("t1_araddr", 64'(ar_addr_at(ab)), 64'h8000_0080);
      chk("t1_arlen",  64'(ar_len_at(ab)),  64'(3));
      chk("t1_arattr", 64'(ar_attr_at(ab)), 64'({8'h5A, 3'd3, 2'b01}));
      chk_last("t1", rb, 4);
      chk("t1_rd_err", 64'(rd_err), 64'(0));

      // Three strided rows of 2 beats, stride 16 words
      ab = ar_addr_log.size(); rb = rx_last_log.size();
      send(8'h11, 10'h000, 8'd1, 3'd1, 8'd2);
      wait_idle("t2", 1'b0);
      chk("t2_ar_n",  64'(ar_addr_log.size() - ab), 64'(3));
      chk("t2_addr0", 64'(ar_addr_at(ab)),     64'h8000_0000);
      chk("t2_addr1", 64'(ar_addr_at(ab + 1)), 64'h8000_0080);
      chk("t2_addr2", 64'(ar_addr_at(ab + 2)), 64'h8000_0100);
      chk("t2_len2",  64'(ar_len_at(ab + 2)),  64'(1));
      chk_last("t2", rb, 6);

      // Outstanding limit with memory withholding R
      mem_hold = 1'b1;
      ab = ar_addr_log.size(); rb = rx_last_log.size();
      send(8'h22, 10'h000, 8'd0, 3'd0, 8'd7);
      step(20);
      chk("t3_ar_held",   64'(ar_addr_log.size() - ab), 64'(4));
      chk("t3_arvalid_lo", 64'(mem.m_arvalid), 64'(0));
      mem_hold = 1'b0;
      wait_idle("t3", 1'b0);
      chk("t3_ar_n",  64'(ar_addr_log.size() - ab), 64'(8));
      chk("t3_addr7", 64'(ar_addr_at(ab + 7)), 64'h8000_01C0);
      chk_last("t3", rb, 8);

      // LSU backpressure, 8-beat burst
      ab = ar_addr_log.size(); rb = rx_last_log.size();
      send(8'h33, 10'h040, 8'd7, 3'd0, 8'd0);
      wait_idle("t4", 1'b1);
      chk("t4_addr", 64'(ar_addr_at(ab)), 64'h8000_0200);
      chk_last("t4", rb, 8);

      // 4 KB crossing flags rd_err; burst issued unmodified
      mem_hold = 1'b1;
      ab = ar_addr_log.size(); rb = rx_last_log.size();
      send(8'h44, 10'h1FE, 8'd3, 3'd0, 8'd0);
      t = 0;
      while (ar_addr_log.size() == ab && t < 50) begin
         step(1);
         t++;
      end
      step(1);
      chk("t5_err_4k", 64'(rd_err), 64'(1));
      mem_hold = 1'b0;
      wait_idle("t5a", 1'b0);
      chk("t5_err_sticky", 64'(rd_err), 64'(1));
      chk("t5_addr",  64'(ar_addr_at(ab)), 64'h8000_0FF0);
      chk("t5_len",   64'(ar_len_at(ab)),  64'(3));
      chk_last("t5a", rb, 4);

      // Accept clears rd_err; SLVERR beat sets it and is forwarded
      rb = rx_last_log.size();
      err_gbeat = gcount + 1;
      send(8'h45, 10'h020, 8'd1, 3'd0, 8'd0);
      chk("t5_err_clr", 64'(rd_err), 64'(0));
      wait_idle("t5b", 1'b0);
      err_gbeat = -1;
      chk("t5_err_resp", 64'(rd_err), 64'(1));
      chk("t5_resp_b0", 64'(rx_resp_at(rb)),     64'(0));
      chk("t5_resp_b1", 64'(rx_resp_at(rb + 1)), 64'(2));

      // Row ending exactly on a 4 KB boundary is not an error
      ab = ar_addr_log.size();
      send(8'h46, 10'h1FC, 8'd3, 3'd0, 8'd0);
      chk("t5c_err_clr", 64'(rd_err), 64'(0));
      wait_idle("t5c", 1'b0);
      chk("t5_err_exact4k", 64'(rd_err), 64'(0));
      chk("t5c_addr", 64'(ar_addr_at(ab)), 64'h8000_0FE0);

      // Reset while issuing, after 1 of 3 ARs
      mem_hold  = 1'b1;
      mem_arrdy = 1'b0;
      ab = ar_addr_log.size();
      send(8'h55, 10'h000, 8'd1, 3'd1, 8'd2);
      t = 0;
      while (mem.m_arvalid !== 1'b1 && t < 50) begin
         step(1);
         t++;
      end
      mem_arrdy = 1'b1;
      step(1);
      mem_arrdy = 1'b0;
      step(3);
      chk("t6_one_ar",       64'(ar_addr_log.size() - ab), 64'(1));
      chk("t6_arvalid_held", 64'(mem.m_arvalid), 64'(1));
      rst = 1'b1;
      #1;
      chk_reset("t6_async");
      step(1);
      chk_reset("t6_rst");
      rst       = 1'b0;
      mem_hold  = 1'b0;
      mem_arrdy = 1'b1;
      step(2);
      ab = ar_addr_log.size(); rb = rx_last_log.size();
      send(8'h56, 10'h008, 8'd1, 3'd1, 8'd2);
      wait_idle("t6", 1'b0);
      chk("t6_ar_n",  64'(ar_addr_log.size() - ab), 64'(3));
      chk("t6_addr0", 64'(ar_addr_at(ab)),     64'h8000_0040);
      chk("t6_addr1", 64'(ar_addr_at(ab + 1)), 64'h8000_00C0);
      chk("t6_addr2", 64'(ar_addr_at(ab + 2)), 64'h8000_0140);
      chk_last("t6", rb, 6);

      step(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
